// File: rtl/dec_onehot_hold_if.sv
// ============================================================================
// Module   : dec_onehot_hold_if
// Brief    : Code-in / one-hot-out bundle for the holding one-hot decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dec_onehot_hold_if #(
    parameter int N = 2
);
    logic [N-1:0]      in_code;
    logic              in_valid;
    logic              in_ready;
    logic              abort;
    logic [(1<<N)-1:0] out_onehot;
    logic              out_valid;
    logic              done;

    modport master (
        output in_code, in_valid, abort,
        input  in_ready, out_onehot, out_valid, done
    );

    modport slave (
        input  in_code, in_valid, abort,
        output in_ready, out_onehot, out_valid, done
    );
endinterface

`default_nettype wire

// File: rtl/dec_onehot_hold.sv
// ============================================================================
// Module   : dec_onehot_hold
// Brief    : N-to-2^N one-hot decoder; holds the decoded line HOLD_CYC cycles,
//            then pulses done. Accepts codes over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_onehot_hold #(
    parameter int N        = 2,
    parameter int HOLD_CYC = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    dec_onehot_hold_if.slave bus
);
    localparam int W  = 1 << N;
    localparam int CW = $clog2(HOLD_CYC + 1);

    localparam logic [0:0]    S_IDLE      = 1'b0;
    localparam logic [0:0]    S_HOLD      = 1'b1;
    localparam logic [W-1:0]  c_one       = W'(1);
    localparam logic [CW-1:0] c_hold_last = CW'(HOLD_CYC - 1);

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_onehot;
    logic          r_valid;
    logic          r_done;
    logic          w_ready;
    logic          w_accept;

    assign w_ready  = (r_state == S_IDLE) && !bus.abort;
    assign w_accept = bus.in_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_onehot <= c_one << bus.in_code;
                        r_valid  <= 1'b1;
                        r_cnt    <= c_hold_last;
                        r_state  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // abort takes priority over a hold that is finishing this cycle
                    if (bus.abort) begin
                        r_onehot <= '0;
                        r_valid  <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_IDLE;
                    end else if (r_cnt == '0) begin
                        r_onehot <= '0;
                        r_valid  <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_onehot <= '0;
                    r_valid  <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.out_onehot = r_onehot;
    assign bus.out_valid  = r_valid;
    assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_dec_onehot_hold.sv
// ============================================================================
// Module   : tb_dec_onehot_hold
// Brief    : Random + directed bench against a timestamp-based decoder model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_onehot_hold;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dec_onehot_hold_if #(.N(2)) bus_a ();
    dec_onehot_hold_if #(.N(3)) bus_b ();

    dec_onehot_hold #(.N(2), .HOLD_CYC(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    dec_onehot_hold #(.N(3), .HOLD_CYC(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a hold is described only by its accept edge index and code
    bit sel;
    int h;
    int e;
    bit m_active;
    int m_acc;
    int m_code;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_idle();
        return !m_active || (e - m_acc) >= h;
    endfunction

    function automatic logic [31:0] got_onehot();
        return sel ? 32'(bus_b.out_onehot) : 32'(bus_a.out_onehot);
    endfunction

    task automatic check_outputs(input string tag);
        bit vld;
        bit dn;
        vld = m_active && (e - m_acc) < h;
        dn  = m_active && (e - m_acc) == h;
        chk({tag, ".onehot"}, got_onehot(), vld ? (32'd1 << m_code) : 32'd0);
        chk({tag, ".valid"}, sel ? 32'(bus_b.out_valid) : 32'(bus_a.out_valid), 32'(vld));
        chk({tag, ".done"}, sel ? 32'(bus_b.done) : 32'(bus_a.done), 32'(dn));
    endtask

    // Called just after a rising edge; drives, checks ready, clocks, checks outputs
    task automatic step(input bit v, input int code, input bit ab, input string tag);
        bit idle;
        if (sel) begin
            bus_b.in_valid = v; bus_b.in_code = 3'(code); bus_b.abort = ab;
        end else begin
            bus_a.in_valid = v; bus_a.in_code = 2'(code); bus_a.abort = ab;
        end
        @(negedge clk);
        idle = m_idle();
        chk({tag, ".ready"}, sel ? 32'(bus_b.in_ready) : 32'(bus_a.in_ready), 32'(idle && !ab));
        @(posedge clk);
        e++;
        if (idle && v && !ab) begin
            m_active = 1'b1;
            m_acc    = e;
            m_code   = code;
        end else if (!idle && ab) begin
            m_active = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        bus_a.in_valid = 1'b0; bus_a.in_code = '0; bus_a.abort = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_code = '0; bus_b.abort = 1'b0;
    endtask

    task automatic random_steps(input int n, input int max_code, input string tag);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, max_code),
                 $urandom_range(0, 9) == 0, tag);
    endtask

    initial begin
        idle_inputs();
        sel = 1'b0; h = 4; e = 0; m_active = 1'b0; m_acc = 0; m_code = 0;

        @(posedge clk); #1;
        chk("rst.onehot_a", 32'(bus_a.out_onehot), 32'd0);
        chk("rst.valid_a", 32'(bus_a.out_valid), 32'd0);
        chk("rst.done_a", 32'(bus_a.done), 32'd0);
        chk("rst.onehot_b", 32'(bus_b.out_onehot), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.ready_a", 32'(bus_a.in_ready), 32'd1);
        @(posedge clk); #1;

        // Sweep of all codes with idle gaps
        for (int c = 0; c < 4; c++) begin
            step(1'b1, c, 1'b0, "sweep");
            repeat (5) step(1'b0, 0, 1'b0, "sweep");
        end

        // Continuous valid: accepted again in each done cycle
        repeat (16) step(1'b1, 2, 1'b0, "cont");
        repeat (5) step(1'b0, 0, 1'b0, "cont");

        // Code change mid-hold must not disturb the held output
        step(1'b1, 1, 1'b0, "chg");
        repeat (10) step(1'b1, 3, 1'b0, "chg");
        repeat (5) step(1'b0, 0, 1'b0, "chg");

        // Abort on hold cycle 2, then on the last hold cycle
        step(1'b1, 3, 1'b0, "abort2");
        step(1'b0, 0, 1'b0, "abort2");
        step(1'b0, 0, 1'b1, "abort2");
        repeat (2) step(1'b0, 0, 1'b0, "abort2");
        step(1'b1, 3, 1'b0, "abortL");
        repeat (3) step(1'b0, 0, 1'b0, "abortL");
        step(1'b0, 0, 1'b1, "abortL");
        repeat (2) step(1'b0, 0, 1'b0, "abortL");
        step(1'b1, 1, 1'b1, "abortIdle");
        step(1'b0, 0, 1'b0, "abortIdle");

        // Asynchronous reset between edges while 0100 is held
        step(1'b1, 2, 1'b0, "arst");
        step(1'b0, 0, 1'b0, "arst");
        #3;
        rst_n = 1'b0;
        #1;
        m_active = 1'b0;
        chk("arst.onehot", 32'(bus_a.out_onehot), 32'd0);
        chk("arst.valid", 32'(bus_a.out_valid), 32'd0);
        chk("arst.done", 32'(bus_a.done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 0, 1'b0, "post");
        repeat (5) step(1'b0, 0, 1'b0, "post");

        random_steps(400, 3, "rand_a");
        idle_inputs();
        repeat (5) step(1'b0, 0, 1'b0, "drain_a");

        // Corner configuration: N=3, HOLD_CYC=1
        sel = 1'b1; h = 1; m_active = 1'b0;
        step(1'b1, 5, 1'b0, "b.code5");
        chk("b.code5.bits", got_onehot(), 32'h20);
        step(1'b0, 0, 1'b0, "b.done");
        step(1'b0, 0, 1'b0, "b.idle");
        repeat (6) step(1'b1, 7, 1'b0, "b.cont");
        random_steps(200, 7, "rand_b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
